// File: rtl/kcp53k_pkg.sv
// kcp53k_pkg: shared register-index types and widths for the KCP53K writeback scoreboard.
// Build option: SCOREBOARD_SAMECYCLE_EN (see wb_scoreboard.sv).
package kcp53k_pkg;

    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;    // enough for MAX_INFLIGHT up to 15

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [NREGS-1:0] reg_mask_t;

    // True when an index names a real architectural destination (x0 is never tracked)
    function automatic logic is_real_reg(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/wb_pending_mask.sv
// wb_pending_mask: one pending bit per architectural register, x0 forced to zero.
// A set and a clear of the same register in one cycle leaves the bit set (issue wins).
// Three combinational lookups serve the ra/rb/rd hazard checks; the full mask is exported too.
module wb_pending_mask
    import kcp53k_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 set_en,
    input  logic [REG_W-1:0]     set_idx,
    input  logic                 clr_en,
    input  logic [REG_W-1:0]     clr_idx,
    input  logic [REG_W-1:0]     idx_a,
    input  logic [REG_W-1:0]     idx_b,
    input  logic [REG_W-1:0]     idx_d,
    output logic                 pend_a,
    output logic                 pend_b,
    output logic                 pend_d,
    output logic [NREGS-1:0]     mask
);

    logic [NREGS-1:0] mask_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            if (gi == 0) begin : g_x0
                // x0 is architecturally zero and can never be pending
                assign mask_reg[gi] = 1'b0;
            end else begin : g_reg
                // Per-register pending flag: set on tracked issue, cleared on completion
                always_ff @(posedge clk_i or negedge reset_ni) begin
                    if (!reset_ni) begin
                        mask_reg[gi] <= 1'b0;
                    end else if (set_en && (set_idx == REG_W'(gi))) begin
                        mask_reg[gi] <= 1'b1;
                    end else if (clr_en && (clr_idx == REG_W'(gi))) begin
                        mask_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign pend_a = mask_reg[idx_a];
    assign pend_b = mask_reg[idx_b];
    assign pend_d = mask_reg[idx_d];
    assign mask   = mask_reg;

endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks in-flight register writes, stalls issue on RAW/WAW hazards or a full
// in-flight window, passes completions to the register file and holds each completed
// rd/data for exactly one cycle for the bypass forwarder.
// Build option: SCOREBOARD_SAMECYCLE_EN -- when defined, a register completing this cycle is
// treated as already free by the hazard and capacity checks (longer path, one less stall cycle).
module wb_scoreboard
    import kcp53k_pkg::*;
#(
    parameter int XLEN         = kcp53k_pkg::XLEN,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              iss_valid_i,
    input  logic [4:0]        iss_ra_i,
    input  logic [4:0]        iss_rb_i,
    input  logic [4:0]        iss_rd_i,
    input  logic              iss_we_i,
    output logic              iss_ready_o,
    input  logic              cmp_valid_i,
    input  logic [4:0]        cmp_rd_i,
    input  logic [XLEN-1:0]   cmp_dat_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_rd_o,
    output logic [XLEN-1:0]   rf_dat_o,
    output logic [4:0]        fwd_rd_o,
    output logic [XLEN-1:0]   fwd_dat_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_eff;
    logic [4:0]       fwd_rd_reg;
    logic [XLEN-1:0]  fwd_dat_reg;
    logic             err_reg;

    logic             pend_a;
    logic             pend_b;
    logic             pend_d;
    logic [NREGS-1:0] mask;

    logic             cmp_live;     // completion to a real register
    logic             cmp_hit;      // ...and that register was pending
    logic             iss_track;    // issue would create a tracked write
    logic             haz_a;
    logic             haz_b;
    logic             haz_d;
    logic             ready;
    logic             fire_track;

    wb_pending_mask u_mask (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .set_en   (fire_track),
        .set_idx  (iss_rd_i),
        .clr_en   (cmp_live),
        .clr_idx  (cmp_rd_i),
        .idx_a    (iss_ra_i),
        .idx_b    (iss_rb_i),
        .idx_d    (iss_rd_i),
        .pend_a   (pend_a),
        .pend_b   (pend_b),
        .pend_d   (pend_d),
        .mask     (mask)
    );

    assign cmp_live  = cmp_valid_i && is_real_reg(cmp_rd_i);
    assign cmp_hit   = cmp_live && mask[cmp_rd_i];
    assign iss_track = iss_we_i && is_real_reg(iss_rd_i);

`ifdef SCOREBOARD_SAMECYCLE_EN
    // A register retiring this cycle no longer blocks, and its slot is already free
    assign haz_a     = pend_a && !(cmp_live && (cmp_rd_i == iss_ra_i));
    assign haz_b     = pend_b && !(cmp_live && (cmp_rd_i == iss_rb_i));
    assign haz_d     = pend_d && !(cmp_live && (cmp_rd_i == iss_rd_i));
    assign count_eff = count_reg - {{(CNT_W-1){1'b0}}, cmp_hit};
`else
    // Registered state only: a same-cycle completion frees the register one cycle later
    assign haz_a     = pend_a;
    assign haz_b     = pend_b;
    assign haz_d     = pend_d;
    assign count_eff = count_reg;
`endif

    assign ready      = !(haz_a || haz_b || (iss_we_i && haz_d) ||
                          (iss_track && (count_eff == MAX_CNT)));
    assign fire_track = iss_valid_i && ready && iss_track;

    assign count_next = count_reg + {{(CNT_W-1){1'b0}}, fire_track}
                                  - {{(CNT_W-1){1'b0}}, cmp_hit};

    // In-flight count, one-cycle forward register and sticky error flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_reg   <= '0;
            fwd_rd_reg  <= '0;
            fwd_dat_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (cmp_live) begin
                fwd_rd_reg  <= cmp_rd_i;
                fwd_dat_reg <= cmp_dat_i;
            end else begin
                fwd_rd_reg  <= '0;
                fwd_dat_reg <= '0;
            end
            if (cmp_live && !mask[cmp_rd_i]) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign iss_ready_o = ready;
    assign rf_we_o     = cmp_live;
    assign rf_rd_o     = cmp_rd_i;
    assign rf_dat_o    = cmp_dat_i;
    assign fwd_rd_o    = fwd_rd_reg;
    assign fwd_dat_o   = fwd_dat_reg;
    assign busy_o      = (count_reg != '0);
    assign err_o       = err_reg;

endmodule
